// File: rtl/quad_step_decoder.sv
// Quadrature step decoder.
// Synchronizes an asynchronous A/B encoder pair and turns each legal Gray-code
// phase change into a one-cycle step pulse with direction. It keeps a wrapping
// position count that follows the same steps, and it latches a sticky error
// when both phases change between two consecutive samples.
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             clear,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] position,
  output logic             err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } state_t;

  // Reject synchronizer depths the priming logic is not built for.
  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("quad_step_decoder: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             ph;
  logic [1:0]             ph_next;

  state_t                 state_q;
  logic [CNT_W-1:0]       prime_cnt_q;
  logic [1:0]             prev_q;
  logic                   step_q;
  logic                   dir_q;
  logic                   err_q;
  logic [WIDTH-1:0]       pos_q;

  logic                   dec_up;
  logic                   dec_dn;
  logic                   dec_bad;

  // True when cur is the next phase in the A-leads (count up) sequence
  // 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic is_up(input logic [1:0] prev, input logic [1:0] cur);
    logic r;
    case (prev)
      2'b00:   r = (cur == 2'b10);
      2'b10:   r = (cur == 2'b11);
      2'b11:   r = (cur == 2'b01);
      default: r = (cur == 2'b00);
    endcase
    return r;
  endfunction

  // True when cur is the next phase in the B-leads (count down) sequence
  // 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic is_down(input logic [1:0] prev, input logic [1:0] cur);
    logic r;
    case (prev)
      2'b00:   r = (cur == 2'b01);
      2'b01:   r = (cur == 2'b11);
      2'b11:   r = (cur == 2'b10);
      default: r = (cur == 2'b00);
    endcase
    return r;
  endfunction

  // Both phases flipped in one sample: direction is unknowable.
  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev ^ cur) == 2'b11);
  endfunction

  // Settled phase pair, and the value it takes on the coming edge.
  assign ph      = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign ph_next = {a_sync_q[SYNC_STAGES-2], b_sync_q[SYNC_STAGES-2]};

  // Classify the transition from the previous sample to the current one.
  always_comb begin
    dec_up  = is_up(prev_q, ph);
    dec_dn  = is_down(prev_q, ph);
    dec_bad = is_illegal(prev_q, ph);
  end

  // Synchronizer chains for the asynchronous encoder pins; bit 0 is the first flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], quad_a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], quad_b};
    end
  end

  // Prime/run controller with registered step, direction, position and error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PRIME;
      prime_cnt_q <= '0;
      prev_q      <= 2'b00;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      pos_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_PRIME: begin
          step_q <= 1'b0;
          if (prime_cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
            // Seed prev with the value ph assumes on this very edge, so the
            // first RUN compare sees settled pins rather than the zeros left
            // in the chains by reset.
            prev_q  <= ph_next;
            state_q <= ST_RUN;
          end else begin
            prime_cnt_q <= prime_cnt_q + CNT_W'(1);
          end
          if (clear) begin
            pos_q <= '0;
            err_q <= 1'b0;
          end
        end
        ST_RUN: begin
          prev_q <= ph;
          step_q <= dec_up | dec_dn;
          if (dec_up) begin
            dir_q <= 1'b1;
            pos_q <= pos_q + WIDTH'(1);
          end else if (dec_dn) begin
            dir_q <= 1'b0;
            pos_q <= pos_q - WIDTH'(1);
          end
          if (dec_bad) begin
            err_q <= 1'b1;
          end
          // Clear beats any count or error update on the same edge; the
          // step pulse and direction still report what was decoded.
          if (clear) begin
            pos_q <= '0;
            err_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_PRIME;
        end
      endcase
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign position = pos_q;
  assign err      = err_q;

endmodule
